// File: rtl/execute_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : execute_stage_pkg
//  Purpose  : Shared definitions for the execute stage and its neighbours:
//             opcode encodings (LOAD/STORE are also decoded by the
//             memory-access stage), the bubble opcode, the datapath width
//             and the execute-stage FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package execute_stage_pkg;

  localparam int DATA_W     = 16;
  localparam int MUL_CYCLES = 16;

  // Opcode encodings
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SHL   = 4'b0101;
  localparam logic [3:0] OP_SHR   = 4'b0110;
  localparam logic [3:0] OP_MUL   = 4'b0111;
  localparam logic [3:0] OP_LOAD  = 4'b1100;
  localparam logic [3:0] OP_STORE = 4'b1110;
  localparam logic [3:0] OP_NOP   = 4'b1111;

  // Opcode carried by a pipeline bubble
  localparam logic [3:0] CTRL_BUBBLE = OP_NOP;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_RUN  = 2'd1,
    ST_MUL_DONE = 2'd2
  } ex_state_e;

  // Single-cycle opcodes that produce a real (non-bubble) result.
  function automatic logic is_single_cycle_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_LOAD, OP_STORE: is_single_cycle_op = 1'b1;
      default:                           is_single_cycle_op = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_iter_16.sv
`default_nettype none
// ============================================================================
//  Module   : mul_iter_16
//  Purpose  : Iterative shift-add multiplier, one partial product per cycle.
//             Returns the low WIDTH bits of op_a * op_b.
//  Ports    : clk, reset_n (async, active low)
//             start   - load operands, clear accumulator and counter
//             abort   - drop the current operation (wins over start)
//             op_a/b  - operands, sampled only on start
//             busy    - iterations in progress
//             done    - final iteration is being performed this cycle
//             product - accumulator; valid the cycle after done
//  Revision : 1.0  initial release
// ============================================================================
module mul_iter_16
  import execute_stage_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int ITERS = MUL_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int              CNT_W    = $clog2(ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             busy_q,   busy_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;

    if (abort) begin
      acc_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (start) begin
      mcand_d  = op_a;
      mplier_d = op_b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      // Multiplicand moves left, multiplier right: bit i of op_b selects
      // op_a << i. Bits shifted past WIDTH are discarded (modulo result).
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CNT_LAST);
  assign product = acc_q;

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
//  Module   : execute_stage
//  Purpose  : Execute stage of the 16-bit in-order pipeline. Single-cycle ALU
//             and address generation, plus an iterative multiplier that
//             stalls decode while it runs. All outputs come from a registered
//             boundary feeding the memory-access stage.
//  Ports    : clk, reset_n (async, active low)
//             *_id  inputs  - instruction from decode (held while stall_ex)
//             flush_ex      - kill current instruction, highest priority
//             stall_ex      - hold decode (combinational)
//             *_ex  outputs - registered instruction to memory access
//  Revision : 1.0  initial release
// ============================================================================
module execute_stage #(
  parameter int DATA_W     = execute_stage_pkg::DATA_W,
  parameter int MUL_CYCLES = execute_stage_pkg::MUL_CYCLES  // must equal DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_id,
  input  logic [3:0]        control_id,
  input  logic [DATA_W-1:0] op_a_id,
  input  logic [DATA_W-1:0] op_b_id,
  input  logic [DATA_W-1:0] imm_id,
  input  logic [DATA_W-1:0] store_data_id,
  input  logic [4:0]        dest_reg_index_id,
  input  logic              dest_reg_write_en_id,
  input  logic              flush_ex,
  output logic              stall_ex,
  output logic [3:0]        control_ex,
  output logic [DATA_W-1:0] result_ex,
  output logic [DATA_W-1:0] reg_data_ex,
  output logic [4:0]        dest_reg_index_ex,
  output logic              dest_reg_write_en_ex
);

  import execute_stage_pkg::*;

  ex_state_e         state_q, state_d;
  logic [3:0]        control_q, control_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] reg_data_q, reg_data_d;
  logic [4:0]        dest_idx_q, dest_idx_d;
  logic              dest_we_q, dest_we_d;

  logic              mul_req;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;
  logic [DATA_W-1:0] alu_result;

  assign mul_req   = valid_id && (control_id == OP_MUL) && !flush_ex;
  assign mul_start = (state_q == ST_IDLE) && mul_req;

  mul_iter_16 #(
    .WIDTH (DATA_W),
    .ITERS (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .abort   (flush_ex),
    .op_a    (op_a_id),
    .op_b    (op_b_id),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Gated by reset_n so decode is never held while the stage is in reset,
  // whatever the inputs are doing.
  assign stall_ex = reset_n && !flush_ex &&
                    ((state_q == ST_MUL_RUN) || mul_start);

  always_comb begin
    alu_result = '0;
    case (control_id)
      OP_ADD:            alu_result = op_a_id + op_b_id;
      OP_SUB:            alu_result = op_a_id - op_b_id;
      OP_AND:            alu_result = op_a_id & op_b_id;
      OP_OR:             alu_result = op_a_id | op_b_id;
      OP_XOR:            alu_result = op_a_id ^ op_b_id;
      OP_SHL:            alu_result = op_a_id << op_b_id[3:0];
      OP_SHR:            alu_result = op_a_id >> op_b_id[3:0];
      OP_LOAD, OP_STORE: alu_result = op_a_id + imm_id;
      default:           alu_result = '0;
    endcase
  end

  // Next state and next pipeline-register contents. Every path that does
  // not explicitly produce an instruction leaves the bubble defaults.
  always_comb begin
    state_d    = state_q;
    control_d  = CTRL_BUBBLE;
    result_d   = '0;
    reg_data_d = '0;
    dest_idx_d = '0;
    dest_we_d  = 1'b0;

    if (flush_ex) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mul_req) begin
            state_d = ST_MUL_RUN;
          end else if (valid_id && is_single_cycle_op(control_id)) begin
            control_d  = control_id;
            result_d   = alu_result;
            reg_data_d = (control_id == OP_STORE) ? store_data_id : '0;
            dest_idx_d = dest_reg_index_id;
            dest_we_d  = dest_reg_write_en_id;
          end
        end
        ST_MUL_RUN: begin
          if (mul_done) begin
            state_d = ST_MUL_DONE;
          end else if (!mul_busy) begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL_DONE: begin
          // Decode still holds the MUL, so its dest fields are current.
          control_d  = OP_MUL;
          result_d   = mul_product;
          dest_idx_d = dest_reg_index_id;
          dest_we_d  = dest_reg_write_en_id;
          state_d    = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      control_q  <= CTRL_BUBBLE;
      result_q   <= '0;
      reg_data_q <= '0;
      dest_idx_q <= '0;
      dest_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      control_q  <= control_d;
      result_q   <= result_d;
      reg_data_q <= reg_data_d;
      dest_idx_q <= dest_idx_d;
      dest_we_q  <= dest_we_d;
    end
  end

  assign control_ex           = control_q;
  assign result_ex            = result_q;
  assign reg_data_ex          = reg_data_q;
  assign dest_reg_index_ex    = dest_idx_q;
  assign dest_reg_write_en_ex = dest_we_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_execute_stage
//  Purpose  : Self-checking bench for execute_stage. Stimulus pushes the
//             expected output (with the cycle it must appear in) into a
//             scoreboard queue; a monitor pops and compares whenever the DUT
//             presents a non-bubble instruction, and checks bubbles are clean.
//  Revision : 1.0  initial release
// ============================================================================
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        valid_id = 1'b0;
  logic [3:0]  control_id = OP_NOP;
  logic [15:0] op_a_id = '0;
  logic [15:0] op_b_id = '0;
  logic [15:0] imm_id = '0;
  logic [15:0] store_data_id = '0;
  logic [4:0]  dest_reg_index_id = '0;
  logic        dest_reg_write_en_id = 1'b0;
  logic        flush_ex = 1'b0;
  logic        stall_ex;
  logic [3:0]  control_ex;
  logic [15:0] result_ex;
  logic [15:0] reg_data_ex;
  logic [4:0]  dest_reg_index_ex;
  logic        dest_reg_write_en_ex;

  execute_stage dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .valid_id             (valid_id),
    .control_id           (control_id),
    .op_a_id              (op_a_id),
    .op_b_id              (op_b_id),
    .imm_id               (imm_id),
    .store_data_id        (store_data_id),
    .dest_reg_index_id    (dest_reg_index_id),
    .dest_reg_write_en_id (dest_reg_write_en_id),
    .flush_ex             (flush_ex),
    .stall_ex             (stall_ex),
    .control_ex           (control_ex),
    .result_ex            (result_ex),
    .reg_data_ex          (reg_data_ex),
    .dest_reg_index_ex    (dest_reg_index_ex),
    .dest_reg_write_en_ex (dest_reg_write_en_ex)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [3:0]  ctrl;
    logic [15:0] res;
    logic [15:0] rd;
    logic [4:0]  idx;
    logic        we;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass  = 0;
  bit   mon_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: sample at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (control_ex !== OP_NOP) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 64'(control_ex), 64'(OP_NOP));
        end else begin
          mon_e = sb.pop_front();
          chk("out_cycle",    64'(cyc),                  64'(mon_e.cyc));
          chk("out_control",  64'(control_ex),           64'(mon_e.ctrl));
          chk("out_result",   64'(result_ex),            64'(mon_e.res));
          chk("out_reg_data", 64'(reg_data_ex),          64'(mon_e.rd));
          chk("out_dest_idx", 64'(dest_reg_index_ex),    64'(mon_e.idx));
          chk("out_dest_we",  64'(dest_reg_write_en_ex), 64'(mon_e.we));
        end
      end else begin
        chk("bubble_fields",
            64'({result_ex, reg_data_ex, dest_reg_index_ex, dest_reg_write_en_ex}), 64'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_id   = 1'b0;
    control_id = OP_NOP;
    flush_ex   = 1'b0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] imm, input logic [15:0] sd,
                       input logic [4:0] idx, input logic we);
    valid_id             = 1'b1;
    control_id           = op;
    op_a_id              = a;
    op_b_id              = b;
    imm_id               = imm;
    store_data_id        = sd;
    dest_reg_index_id    = idx;
    dest_reg_write_en_id = we;
  endtask

  // Single-cycle op: result must appear in the next cycle.
  task automatic alu_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] imm, input logic [15:0] sd,
                        input logic [4:0] idx, input logic we,
                        input logic [15:0] exp_res, input logic [15:0] exp_rd);
    drive(op, a, b, imm, sd, idx, we);
    sb.push_back('{cyc: cyc + 1, ctrl: op, res: exp_res, rd: exp_rd, idx: idx, we: we});
    tick();
  endtask

  // MUL: expects 17 stall cycles and the product 18 cycles after issue.
  // Operand inputs are scrambled mid-run; only the latched copies may count.
  task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] idx, input logic we, input logic [15:0] exp_p);
    int n;
    drive(OP_MUL, a, b, 16'h1111, 16'h2222, idx, we);
    sb.push_back('{cyc: cyc + 18, ctrl: OP_MUL, res: exp_p, rd: 16'h0, idx: idx, we: we});
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 3) begin
        op_a_id = ~a;
        op_b_id = 16'h5A5A;
      end
      if (stall_ex) n++;
      else break;
    end
    chk("mul_stall_cycles", 64'(n), 64'(17));
    tick();
    idle();
  endtask

  initial begin
    // Reset with MUL-like junk on the inputs.
    #1 reset_n = 1'b0;
    drive(OP_MUL, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
          5'($urandom), 1'b1);
    repeat (3) tick();
    chk("stall_in_reset", 64'(stall_ex), 64'(0));
    chk("ctrl_in_reset", 64'(control_ex), 64'(OP_NOP));
    idle();
    #2 reset_n = 1'b1;
    tick();
    chk("rst_control",  64'(control_ex), 64'(4'hF));
    chk("rst_result",   64'(result_ex), 64'(0));
    chk("rst_reg_data", 64'(reg_data_ex), 64'(0));
    chk("rst_dest_idx", 64'(dest_reg_index_ex), 64'(0));
    chk("rst_dest_we",  64'(dest_reg_write_en_ex), 64'(0));
    chk("rst_stall",    64'(stall_ex), 64'(0));
    mon_en = 1'b1;

    // ALU ops, back to back.
    alu_op(OP_ADD, 16'h8001, 16'h0003, 16'h0, 16'hAAAA, 5'd1,  1'b1, 16'h8004, 16'h0);
    alu_op(OP_SUB, 16'h8001, 16'h0003, 16'h0, 16'hAAAA, 5'd2,  1'b1, 16'h7FFE, 16'h0);
    alu_op(OP_SHL, 16'h8001, 16'h0003, 16'h0, 16'hAAAA, 5'd3,  1'b0, 16'h0008, 16'h0);
    alu_op(OP_SHR, 16'h8001, 16'h0003, 16'h0, 16'hAAAA, 5'd4,  1'b1, 16'h1000, 16'h0);
    alu_op(OP_XOR, 16'h8001, 16'h0003, 16'h0, 16'hAAAA, 5'd31, 1'b1, 16'h8002, 16'h0);
    alu_op(OP_AND, 16'h8001, 16'h0003, 16'h0, 16'hAAAA, 5'd6,  1'b1, 16'h0001, 16'h0);
    alu_op(OP_OR,  16'h8001, 16'h0003, 16'h0, 16'hAAAA, 5'd7,  1'b1, 16'h8003, 16'h0);
    idle();
    tick();

    // Memory ops.
    alu_op(OP_STORE, 16'h0100, 16'h0, 16'hFFFE, 16'hBEEF, 5'd0, 1'b0, 16'h00FE, 16'hBEEF);
    alu_op(OP_LOAD,  16'h0100, 16'h0, 16'hFFFE, 16'hBEEF, 5'd9, 1'b1, 16'h00FE, 16'h0000);
    idle();
    tick();

    // Multiplies, back to back.
    do_mul(16'h0123, 16'h0011, 5'd5, 1'b1, 16'h1353);
    do_mul(16'hFFFF, 16'hFFFF, 5'd6, 1'b1, 16'h0001);
    repeat (2) tick();

    // Flush at iteration 7.
    drive(OP_MUL, 16'h1234, 16'h0005, 16'h0, 16'h0, 5'd7, 1'b1);
    repeat (8) tick();
    chk("stall_before_flush", 64'(stall_ex), 64'(1));
    flush_ex = 1'b1;
    #1;
    chk("stall_during_flush", 64'(stall_ex), 64'(0));
    tick();
    idle();
    #1;
    chk("stall_after_flush", 64'(stall_ex), 64'(0));
    alu_op(OP_ADD, 16'h0002, 16'h0003, 16'h0, 16'h0, 5'd8, 1'b1, 16'h0005, 16'h0);
    idle();
    repeat (2) tick();

    // Async reset at iteration 10.
    drive(OP_MUL, 16'h00FF, 16'h0002, 16'h0, 16'h0, 5'd10, 1'b1);
    repeat (11) tick();
    chk("stall_before_reset", 64'(stall_ex), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_stall",   64'(stall_ex), 64'(0));
    chk("async_rst_control", 64'(control_ex), 64'(OP_NOP));
    chk("async_rst_fields",
        64'({result_ex, reg_data_ex, dest_reg_index_ex, dest_reg_write_en_ex}), 64'(0));
    idle();
    tick();
    #2 reset_n = 1'b1;
    tick();
    do_mul(16'h0003, 16'h0004, 5'd12, 1'b1, 16'h000C);

    repeat (3) tick();
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 16-bit in-order pipeline. Sits directly upstream of the memory-access stage and drives its control_ex / result_ex / reg_data_ex / dest_reg_index_ex / dest_reg_write_en_ex inputs from a registered pipeline boundary.
- Single-cycle ALU for logic, arithmetic and address generation.
- Iterative shift-add multiplier that stalls the front end while it runs.

Parameters:
- DATA_W, 16, datapath width.
- MUL_CYCLES, 16, multiplier iterations; must equal DATA_W.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous active-low reset.
- valid_id  in  1  decode stage presents a valid instruction.
- control_id  in  4  opcode from decode.
- op_a_id  in  16  source A (register read, already forwarded).
- op_b_id  in  16  source B.
- imm_id  in  16  sign-extended immediate.
- store_data_id  in  16  register value for STORE.
- dest_reg_index_id  in  5  destination register.
- dest_reg_write_en_id  in  1  destination write enable.
- flush_ex  in  1  kill the current instruction (branch redirect).
- stall_ex  out  1  hold decode; upstream keeps all *_id inputs stable while high.
- control_ex  out  4  registered opcode to memory access.
- result_ex  out  16  registered ALU result / memory address.
- reg_data_ex  out  16  registered store data.
- dest_reg_index_ex  out  5  registered destination index.
- dest_reg_write_en_ex  out  1  registered write enable.

Behaviour:
- Opcodes (4 bit): ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SHL 0101, SHR 0110 (logical), MUL 0111, LOAD 1100, STORE 1110, NOP 1111. Any other code is treated as NOP.
- Arithmetic is modulo 2^16; there are no flags. Shift amount is op_b_id[3:0]. MUL returns the low 16 bits of op_a*op_b.
- LOAD/STORE: result = op_a_id + imm_id. reg_data_ex = store_data_id for STORE, 0 otherwise.
- Reset (async, reset_n low): control_ex=NOP, result_ex=0, reg_data_ex=0, dest_reg_index_ex=0, dest_reg_write_en_ex=0, FSM=IDLE, iteration counter=0. stall_ex reads 0 while in reset. An in-flight MUL is dropped.
- Bubble: control_ex=NOP, result_ex=0, reg_data_ex=0, dest_reg_index_ex=0, dest_reg_write_en_ex=0.
- Non-MUL latency: 1 cycle. The inputs sampled at edge N appear on the outputs after edge N.
- valid_id=0 registers a bubble.
- FSM states: IDLE, MUL_RUN, MUL_DONE.
  - IDLE: if valid_id && control_id==MUL && !flush_ex, latch operands, clear the accumulator and counter, go to MUL_RUN, register a bubble.
  - MUL_RUN: one shift-add per cycle. Register a bubble each cycle. When counter==MUL_CYCLES-1, go to MUL_DONE.
  - MUL_DONE: register the product with the held dest_reg_index_id / dest_reg_write_en_id, control=MUL, then go to IDLE.
- stall_ex is combinational: high in MUL_RUN, and in IDLE when valid_id && control_id==MUL && !flush_ex. It is low in MUL_DONE.
- MUL issued at cycle t stalls cycles t..t+16. Decode advances at the end of cycle t+17. The result is visible on the outputs from cycle t+18; total MUL latency is 18 cycles.
- flush_ex has priority over everything. In any state, the next edge registers a bubble and the FSM returns to IDLE with the accumulator discarded. stall_ex drops in the same cycle flush_ex is seen.
- Back-to-back MULs: MUL_DONE always returns to IDLE, so a following MUL starts a fresh 18-cycle sequence with no overlap.
- Operand changes on the *_id inputs during MUL_RUN are ignored; only the latched copies are used.

Decomposition:
- Shared package: the opcode constants (including LOAD=1100 and STORE=1110, also used by the memory-access stage), the NOP/bubble constant, DATA_W, and the FSM state encoding.
- Sub-module mul_iter_16: start, operands, busy, done, product, abort. It holds the counter and the shift-add datapath.
- execute_stage keeps the ALU mux, the FSM control and the pipeline register.

Test Plan:
- Reset: hold reset_n=0 with random inputs, then release → all outputs at bubble values, control_ex=1111, stall_ex=0.
- ALU ops, one cycle each: op_a=0x8001, op_b=0x0003. ADD→0x8004, SUB→0x7FFE, SHL→0x0008, SHR→0x1000, XOR→0x8002, each appearing one cycle after issue with dest fields passed through.
- Memory ops: STORE with op_a=0x0100, imm=0xFFFE (−2), store_data=0xBEEF → result_ex=0x00FE, reg_data_ex=0xBEEF, control_ex=1110. LOAD with the same values → result_ex=0x00FE, reg_data_ex=0.
- Multiply: MUL 0x0123×0x0011, dest r5, write enable 1 → stall_ex high for exactly 17 cycles, bubbles meanwhile, then result_ex=0x1353 with dest r5, control_ex=0111. Then MUL 0xFFFF×0xFFFF → 0x0001.
- Flush mid-MUL: assert flush_ex at iteration 7 → stall_ex drops in the same cycle, bubble registered, FSM in IDLE. A following ADD 2+3 yields 5 after one cycle.
- Async reset during MUL_RUN: pulse reset_n low between clock edges at iteration 10 → outputs go to reset values immediately. After release, a new MUL 3×4 yields 0x000C with full 18-cycle latency.
